// File: rtl/wb_burst_master_if.sv
// Wishbone bus bundle shared by the burst master and its slave.
// Clock and reset travel with the bus so one connection wires a whole endpoint.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst,
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  clk, rst,
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone master: turns one (address, length, direction) command into an
// incrementing burst, fed by a ready/valid write stream and a valid-only read stream.
module wb_burst_master #(
    parameter int LEN_W = 8
) (
    wshb_if.master            wb_m,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [31:0]       cmd_adr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        FIN
    } state_t;

    state_t           state_reg;
    logic             we_reg;
    logic             single_reg;
    logic             err_reg;
    logic [29:0]      word_adr_reg;
    logic [LEN_W-1:0] beats_reg;

    logic in_bus;
    logic stb;
    logic last_beat;
    logic beat_ok;
    logic beat_err;
    logic unused_adr_lsb;

    assign unused_adr_lsb = ^cmd_adr[1:0];

    assign in_bus    = (state_reg == BUS);
    // Reads always strobe; writes strobe only while the client has a word ready.
    assign stb       = in_bus & (~we_reg | wr_valid);
    assign last_beat = (beats_reg == LEN_W'(1));
    // err takes priority over ack; rty is treated as a plain wait.
    assign beat_err  = stb & wb_m.err;
    assign beat_ok   = stb & wb_m.ack & ~wb_m.err & ~wb_m.rty;

    assign wb_m.cyc    = in_bus;
    assign wb_m.stb    = stb;
    assign wb_m.we     = in_bus & we_reg;
    assign wb_m.adr    = in_bus ? {word_adr_reg, 2'b00} : 32'h0;
    assign wb_m.sel    = in_bus ? 4'hF : 4'h0;
    assign wb_m.bte    = 2'b00;
    assign wb_m.dat_ms = wr_data;

    always_comb begin
        wb_m.cti = 3'b000;
        if (in_bus && !single_reg) begin
            wb_m.cti = last_beat ? 3'b111 : 3'b010;
        end
    end

    assign wr_ready  = beat_ok & we_reg;
    assign rd_valid  = beat_ok & ~we_reg;
    assign rd_data   = wb_m.dat_sm;
    assign cmd_ready = (state_reg == IDLE);
    assign done      = (state_reg == FIN);
    assign error     = (state_reg == FIN) & err_reg;

    always_ff @(posedge wb_m.clk or posedge wb_m.rst) begin
        if (wb_m.rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            single_reg   <= 1'b0;
            err_reg      <= 1'b0;
            word_adr_reg <= '0;
            beats_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        we_reg       <= cmd_we;
                        word_adr_reg <= cmd_adr[31:2];
                        beats_reg    <= cmd_len;
                        single_reg   <= (cmd_len == LEN_W'(1));
                        err_reg      <= 1'b0;
                        state_reg    <= (cmd_len != '0) ? BUS : FIN;
                    end
                end
                BUS: begin
                    if (beat_err) begin
                        err_reg   <= 1'b1;
                        state_reg <= FIN;
                    end else if (beat_ok) begin
                        word_adr_reg <= word_adr_reg + 30'd1;
                        beats_reg    <= beats_reg - LEN_W'(1);
                        if (last_beat) begin
                            state_reg <= FIN;
                        end
                    end
                end
                FIN: begin
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
